// File: rtl/immediate_pipeline_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : immediate_pkg
//  Purpose  : Shared constants for the immediate pipeline: 3-bit instruction
//             format codes and RV32I/RV64I major opcodes.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package immediate_pkg;

  // Instruction format codes carried alongside each decoded immediate
  localparam logic [2:0] FORMAT_NONE = 3'd0;
  localparam logic [2:0] FORMAT_R    = 3'd1;
  localparam logic [2:0] FORMAT_I    = 3'd2;
  localparam logic [2:0] FORMAT_S    = 3'd3;
  localparam logic [2:0] FORMAT_B    = 3'd4;
  localparam logic [2:0] FORMAT_U    = 3'd5;
  localparam logic [2:0] FORMAT_J    = 3'd6;

  // Major opcodes, instr[6:0]
  localparam logic [6:0] OPCODE_LOAD      = 7'b0000011;
  localparam logic [6:0] OPCODE_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPCODE_JALR      = 7'b1100111;
  localparam logic [6:0] OPCODE_FENCE     = 7'b0001111;
  localparam logic [6:0] OPCODE_SYSTEM    = 7'b1110011;
  localparam logic [6:0] OPCODE_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPCODE_STORE     = 7'b0100011;
  localparam logic [6:0] OPCODE_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPCODE_LUI       = 7'b0110111;
  localparam logic [6:0] OPCODE_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPCODE_JAL       = 7'b1101111;
  localparam logic [6:0] OPCODE_OP        = 7'b0110011;
  localparam logic [6:0] OPCODE_OP_32     = 7'b0111011;

endpackage : immediate_pkg
`default_nettype wire

// File: rtl/immediate_decode.sv
`default_nettype none
// ============================================================================
//  Module   : immediate_decode
//  Purpose  : Combinational decode of a 32-bit RV32I/RV64I instruction into
//             its format code and sign-extended immediate.
//  Ports    : instruction (in 32)   raw instruction word
//             format      (out 3)   FORMAT_* code
//             immediate   (out XLEN) immediate, sign-extended from instr[31]
//             illegal     (out 1)   only with IMMEDIATE_PIPELINE_ILLEGAL_EN:
//                                   instr[1:0] != 2'b11 or format NONE
//  Options  : IMMEDIATE_PIPELINE_ILLEGAL_EN adds the illegal output.
//  Revision : 1.0 - initial release
// ============================================================================
module immediate_decode
  import immediate_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instruction,
  output logic [2:0]      format,
`ifdef IMMEDIATE_PIPELINE_ILLEGAL_EN
  output logic            illegal,
`endif
  output logic [XLEN-1:0] immediate
);

  logic [6:0]  opcode;
  logic [31:0] imm32;

  assign opcode = instruction[6:0];

  always_comb begin
    format = FORMAT_NONE;
    case (opcode)
      OPCODE_LOAD, OPCODE_OP_IMM, OPCODE_JALR,
      OPCODE_FENCE, OPCODE_SYSTEM:   format = FORMAT_I;
      OPCODE_OP_IMM_32:              format = (XLEN == 64) ? FORMAT_I : FORMAT_NONE;
      OPCODE_STORE:                  format = FORMAT_S;
      OPCODE_BRANCH:                 format = FORMAT_B;
      OPCODE_LUI, OPCODE_AUIPC:      format = FORMAT_U;
      OPCODE_JAL:                    format = FORMAT_J;
      OPCODE_OP:                     format = FORMAT_R;
      OPCODE_OP_32:                  format = (XLEN == 64) ? FORMAT_R : FORMAT_NONE;
      default:                       format = FORMAT_NONE;
    endcase
  end

  // Every 32-bit immediate below has instr[31] in bit 31, so widening to XLEN
  // from imm32[31] is the same as sign extension from the instruction MSB.
  always_comb begin
    imm32 = 32'd0;
    case (format)
      FORMAT_I: imm32 = {{20{instruction[31]}}, instruction[31:20]};
      FORMAT_S: imm32 = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
      FORMAT_B: imm32 = {{19{instruction[31]}}, instruction[31], instruction[7],
                         instruction[30:25], instruction[11:8], 1'b0};
      FORMAT_U: imm32 = {instruction[31:12], 12'd0};
      FORMAT_J: imm32 = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                         instruction[20], instruction[30:21], 1'b0};
      default:  imm32 = 32'd0;
    endcase
  end

  generate
    if (XLEN > 32) begin : g_ext_wide
      assign immediate = {{(XLEN-32){imm32[31]}}, imm32};
    end else begin : g_ext_narrow
      assign immediate = imm32;
    end
  endgenerate

`ifdef IMMEDIATE_PIPELINE_ILLEGAL_EN
  assign illegal = (instruction[1:0] != 2'b11) || (format == FORMAT_NONE);
`endif

endmodule : immediate_decode
`default_nettype wire

// File: rtl/immediate_pipeline.sv
`default_nettype none
// ============================================================================
//  Module   : immediate_pipeline
//  Purpose  : Buffered immediate generator. Instructions accepted on a
//             valid/ready input are decoded and queued in a DEPTH-entry FIFO;
//             the head entry is presented on a valid/ready output.
//  Ports    : clock, reset (sync, active-high)
//             in_valid/in_ready/in_instruction       upstream handshake
//             out_valid/out_ready                    downstream handshake
//             out_instruction/out_immediate/out_format  head entry contents
//             out_illegal   only with IMMEDIATE_PIPELINE_ILLEGAL_EN
//             count         occupied entries
//  Options  : IMMEDIATE_PIPELINE_ILLEGAL_EN adds per-entry illegal flag.
//  Revision : 1.0 - initial release
// ============================================================================
module immediate_pipeline
  import immediate_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_instruction,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_instruction,
  output logic [XLEN-1:0]          out_immediate,
  output logic [2:0]               out_format,
`ifdef IMMEDIATE_PIPELINE_ILLEGAL_EN
  output logic                     out_illegal,
`endif
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [2:0]      dec_format;
  logic [XLEN-1:0] dec_immediate;

  logic [31:0]      instr_mem  [DEPTH];
  logic [XLEN-1:0]  imm_mem    [DEPTH];
  logic [2:0]       format_mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             push;
  logic             pop;

`ifdef IMMEDIATE_PIPELINE_ILLEGAL_EN
  logic dec_illegal;
  logic illegal_mem [DEPTH];
`endif

  immediate_decode #(
    .XLEN (XLEN)
  ) u_decode (
    .instruction (in_instruction),
    .format      (dec_format),
`ifdef IMMEDIATE_PIPELINE_ILLEGAL_EN
    .illegal     (dec_illegal),
`endif
    .immediate   (dec_immediate)
  );

  // No pass-through when full: readiness depends only on current occupancy.
  assign in_ready  = !reset && (count < DEPTH_C);
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        instr_mem[i]  <= '0;
        imm_mem[i]    <= '0;
        format_mem[i] <= FORMAT_NONE;
`ifdef IMMEDIATE_PIPELINE_ILLEGAL_EN
        illegal_mem[i] <= 1'b0;
`endif
      end
    end else begin
      if (push) begin
        instr_mem[wr_ptr]  <= in_instruction;
        imm_mem[wr_ptr]    <= dec_immediate;
        format_mem[wr_ptr] <= dec_format;
`ifdef IMMEDIATE_PIPELINE_ILLEGAL_EN
        illegal_mem[wr_ptr] <= dec_illegal;
`endif
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Head entry is read straight from registered storage, so no in_* to
  // out_* combinational path exists.
  assign out_instruction = instr_mem[rd_ptr];
  assign out_immediate   = imm_mem[rd_ptr];
  assign out_format      = format_mem[rd_ptr];
`ifdef IMMEDIATE_PIPELINE_ILLEGAL_EN
  assign out_illegal     = illegal_mem[rd_ptr];
`endif

endmodule : immediate_pipeline
`default_nettype wire

// File: tb/tb_immediate_pipeline.sv
`default_nettype none
// ============================================================================
//  Module   : tb_immediate_pipeline
//  Purpose  : Directed self-checking bench for immediate_pipeline. Two DUTs
//             (XLEN=32 and XLEN=64, DEPTH=2) share the same stimulus.
//  Options  : IMMEDIATE_PIPELINE_ILLEGAL_EN also checks out_illegal.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_immediate_pipeline;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [31:0] in_instruction;
  logic        out_ready;

  logic        in_ready,  out_valid;
  logic [31:0] out_instruction, out_immediate;
  logic [2:0]  out_format;
  logic [1:0]  count;

  logic        in_ready64, out_valid64;
  logic [31:0] out_instruction64;
  logic [63:0] out_immediate64;
  logic [2:0]  out_format64;
  logic [1:0]  count64;

`ifdef IMMEDIATE_PIPELINE_ILLEGAL_EN
  logic out_illegal, out_illegal64;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  immediate_pipeline #(.XLEN(32), .DEPTH(2)) dut (
    .clock           (clock),
    .reset           (reset),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_instruction  (in_instruction),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_instruction (out_instruction),
    .out_immediate   (out_immediate),
    .out_format      (out_format),
`ifdef IMMEDIATE_PIPELINE_ILLEGAL_EN
    .out_illegal     (out_illegal),
`endif
    .count           (count)
  );

  immediate_pipeline #(.XLEN(64), .DEPTH(2)) dut64 (
    .clock           (clock),
    .reset           (reset),
    .in_valid        (in_valid),
    .in_ready        (in_ready64),
    .in_instruction  (in_instruction),
    .out_valid       (out_valid64),
    .out_ready       (out_ready),
    .out_instruction (out_instruction64),
    .out_immediate   (out_immediate64),
    .out_format      (out_format64),
`ifdef IMMEDIATE_PIPELINE_ILLEGAL_EN
    .out_illegal     (out_illegal64),
`endif
    .count           (count64)
  );

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Advance one rising edge, then settle away from it.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check_head(input string tag, input logic [31:0] instr,
                            input logic [31:0] imm, input logic [2:0] fmt);
    check({tag, ".valid"}, {63'd0, out_valid}, 64'd1);
    check({tag, ".instr"}, {32'd0, out_instruction}, {32'd0, instr});
    check({tag, ".imm"},   {32'd0, out_immediate}, {32'd0, imm});
    check({tag, ".fmt"},   {61'd0, out_format}, {61'd0, fmt});
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_instruction = 32'd0; out_ready = 1'b0;
    step(); step();
    check("rst.in_ready", {63'd0, in_ready}, 64'd0);
    check("rst.count", {62'd0, count}, 64'd0);
    check("rst.out_valid", {63'd0, out_valid}, 64'd0);
    check("rst.instr", {32'd0, out_instruction}, 64'd0);
    check("rst.imm", {32'd0, out_immediate}, 64'd0);
    check("rst.fmt", {61'd0, out_format}, 64'd0);
    reset = 1'b0;
    #1;
    check("post_rst.in_ready", {63'd0, in_ready}, 64'd1);

    // Single I-type load, popped the next cycle
    in_valid = 1'b1; in_instruction = 32'h06002103; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    check_head("lw", 32'h06002103, 32'h00000060, 3'd2);
    check("lw.count", {62'd0, count}, 64'd1);
`ifdef IMMEDIATE_PIPELINE_ILLEGAL_EN
    check("lw.illegal", {63'd0, out_illegal}, 64'd0);
`endif
    step();
    check("lw.drain.count", {62'd0, count}, 64'd0);
    check("lw.drain.valid", {63'd0, out_valid}, 64'd0);

    // LUI, negative upper immediate, both widths
    in_valid = 1'b1; in_instruction = 32'hFFFFF037;
    step();
    in_valid = 1'b0;
    check_head("lui", 32'hFFFFF037, 32'hFFFFF000, 3'd5);
    check("lui.imm64", out_immediate64, 64'hFFFFFFFFFFFFF000);
    check("lui.fmt64", {61'd0, out_format64}, 64'd5);
    step();

    // Back-to-back B, J, S with out_ready high: no bubbles
    in_valid = 1'b1; in_instruction = 32'hFE000EE3;
    step();
    check_head("b2b.beq", 32'hFE000EE3, 32'hFFFFFFFC, 3'd4);
    in_instruction = 32'h0080006F;
    step();
    check_head("b2b.jal", 32'h0080006F, 32'h00000008, 3'd6);
    check("b2b.jal.count", {62'd0, count}, 64'd1);
    in_instruction = 32'h00112623;
    step();
    in_valid = 1'b0;
    check_head("b2b.sw", 32'h00112623, 32'h0000000C, 3'd3);
    step();
    check("b2b.drain.count", {62'd0, count}, 64'd0);

    // Fill with back-pressure, then drain; third push waits for space
    out_ready = 1'b0;
    in_valid = 1'b1; in_instruction = 32'h00100093;
    step();
    in_instruction = 32'h00200113;
    step();
    check("full.count", {62'd0, count}, 64'd2);
    check("full.in_ready", {63'd0, in_ready}, 64'd0);
    in_instruction = 32'h00300193;
    step();
    check("full.hold.count", {62'd0, count}, 64'd2);
    check_head("full.hold", 32'h00100093, 32'd1, 3'd2);
    out_ready = 1'b1;
    step();
    check_head("drain.1", 32'h00200113, 32'd2, 3'd2);
    check("drain.1.count", {62'd0, count}, 64'd1);
    check("drain.1.in_ready", {63'd0, in_ready}, 64'd1);
    step();
    in_valid = 1'b0;
    check_head("drain.2", 32'h00300193, 32'd3, 3'd2);
    check("drain.2.count", {62'd0, count}, 64'd1);
    step();
    check("drain.empty", {62'd0, count}, 64'd0);

    // Reset mid-operation with in_valid held high
    out_ready = 1'b0;
    in_valid = 1'b1; in_instruction = 32'h00400213;
    step();
    check("mid.count", {62'd0, count}, 64'd1);
    reset = 1'b1; in_instruction = 32'h00500293;
    #1;
    check("mid.rst.in_ready", {63'd0, in_ready}, 64'd0);
    step();
    check("mid.rst.count", {62'd0, count}, 64'd0);
    check("mid.rst.valid", {63'd0, out_valid}, 64'd0);
    check("mid.rst.imm", {32'd0, out_immediate}, 64'd0);
    check("mid.rst.instr", {32'd0, out_instruction}, 64'd0);
    reset = 1'b0; in_valid = 1'b0;
    step();
    check("mid.after.valid", {63'd0, out_valid}, 64'd0);

    // Unrecognised encodings; OP_32 differs between widths
    in_valid = 1'b1; in_instruction = 32'h00000000;
    step();
    in_instruction = 32'h0000003B;
    step();
    in_valid = 1'b0;
    check("ill.count", {62'd0, count}, 64'd2);
    check_head("ill.zero", 32'h00000000, 32'd0, 3'd0);
    check("ill.zero.fmt64", {61'd0, out_format64}, 64'd0);
`ifdef IMMEDIATE_PIPELINE_ILLEGAL_EN
    check("ill.zero.illegal", {63'd0, out_illegal}, 64'd1);
`endif
    out_ready = 1'b1;
    step();
    check_head("ill.op32", 32'h0000003B, 32'd0, 3'd0);
    check("ill.op32.fmt64", {61'd0, out_format64}, 64'd1);
    check("ill.op32.imm64", out_immediate64, 64'd0);
`ifdef IMMEDIATE_PIPELINE_ILLEGAL_EN
    check("ill.op32.illegal", {63'd0, out_illegal}, 64'd1);
    check("ill.op32.illegal64", {63'd0, out_illegal64}, 64'd0);
`endif
    step();
    check("end.count", {62'd0, count}, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_immediate_pipeline
`default_nettype wire
